stream_mux_sel: RTL and testbench

- Parametrised N-channel, W-bit streaming multiplexer with a registered output and valid/ready handshakes on every port.
- Selection changes are requested through a load strobe.
- Every selection change goes through a controlled drain-and-blank sequence, so no beat is duplicated, lost or mixed across channels.
- Sits between capture/datapath sources and a single downstream consumer (DMA/FIFO) in the PL fabric.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/stream_out_reg.sv | 34 +++
 rtl/stream_mux_sel.sv | 150 +++++++++++++++
 tb/tb_stream_mux_sel.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux_sel channel multiplexer.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int BLANK_CNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-stage valid/ready output register; data only loads on an accepted beat.
module stream_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign in_ready  = ~r_valid | out_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/stream_mux_sel.sv
// N-channel streaming mux; every channel change drains the output register
// and inserts BLANK idle cycles before the new channel is enabled.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PASS  | selected channel routed to the output register
// ST_DRAIN | all inputs stalled until the held output beat is taken
// ST_BLANK | idle gap of BLANK cycles before switching sel_cur
module stream_mux_sel
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 4,
  parameter  int BLANK = 2,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel_req,
  input  logic                 sel_load,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      sel_cur,
  output logic                 switching,
  output logic                 sel_err
);

  state_t                 r_state, w_state_nxt;
  logic [SELW-1:0]        r_sel_cur, w_sel_nxt;
  logic [SELW-1:0]        r_pend, w_pend_nxt;
  logic [BLANK_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                   r_switching;
  logic                   r_err, w_err_nxt;

  logic                   w_ld;
  logic                   w_pass;
  logic                   w_req_ok;
  logic [WIDTH-1:0]       w_ch_data;
  logic                   w_ch_valid;
  logic                   w_acc_valid;

  assign w_pass      = (r_state == ST_PASS);
  assign w_req_ok    = int'(sel_req) < NCH;
  assign w_acc_valid = w_pass & w_ch_valid;

  always_comb begin
    w_ch_data  = '0;
    w_ch_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (r_sel_cur == SELW'(k)) begin
        w_ch_data  = in_data[k*WIDTH +: WIDTH];
        w_ch_valid = in_valid[k];
      end
    end
  end

  // Only the routed channel sees ready, and never while reset is held.
  always_comb begin
    in_ready = '0;
    if (w_pass && !rst) begin
      for (int k = 0; k < NCH; k++) begin
        in_ready[k] = (r_sel_cur == SELW'(k)) & w_ld;
      end
    end
  end

  stream_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_data  (w_ch_data),
    .in_valid (w_acc_valid),
    .in_ready (w_ld),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel_cur;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_PASS: begin
        if (sel_load) begin
          if (!w_req_ok) begin
            w_err_nxt = 1'b1;
          end else if (sel_req != r_sel_cur) begin
            w_pend_nxt  = sel_req;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_err_nxt = sel_load;
        if (w_ld) begin
          if (BLANK > 0) begin
            w_cnt_nxt   = BLANK_CNT_W'(BLANK - 1);
            w_state_nxt = ST_BLANK;
          end else begin
            w_sel_nxt   = r_pend;
            w_state_nxt = ST_PASS;
          end
        end
      end
      ST_BLANK: begin
        w_err_nxt = sel_load;
        if (r_cnt == '0) begin
          w_sel_nxt   = r_pend;
          w_state_nxt = ST_PASS;
        end else begin
          w_cnt_nxt = r_cnt - BLANK_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_PASS;
      r_sel_cur   <= '0;
      r_pend      <= '0;
      r_cnt       <= '0;
      r_switching <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel_cur   <= w_sel_nxt;
      r_pend      <= w_pend_nxt;
      r_cnt       <= w_cnt_nxt;
      r_switching <= (w_state_nxt != ST_PASS);
      r_err       <= w_err_nxt;
    end
  end

  assign sel_cur   = r_sel_cur;
  assign switching = r_switching;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_stream_mux_sel.sv
// Bench for stream_mux_sel: three builds (NCH=4/BLANK=2, NCH=3/BLANK=2,
// NCH=4/BLANK=0) checked every cycle against a beat/gap-level model.
module tb_stream_mux_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sel_req   [3];
  logic        sel_load  [3];
  logic [63:0] in_data   [3];
  logic [3:0]  in_valid  [3];
  logic        out_ready [3];

  logic [3:0]  ir_a, ir_c;
  logic [2:0]  ir_b;
  logic [15:0] od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
  logic [1:0]  sc_a, sc_b, sc_c;
  logic        sw_a, sw_b, sw_c;
  logic        er_a, er_b, er_c;

  logic [3:0]  ir [3];
  logic [15:0] od [3];
  logic        ov [3];
  logic [1:0]  sc [3];
  logic        swo[3];
  logic        er [3];

  always_comb begin
    ir[0] = ir_a;  ir[1] = {1'b0, ir_b}; ir[2] = ir_c;
    od[0] = od_a;  od[1] = od_b;  od[2] = od_c;
    ov[0] = ov_a;  ov[1] = ov_b;  ov[2] = ov_c;
    sc[0] = sc_a;  sc[1] = sc_b;  sc[2] = sc_c;
    swo[0] = sw_a; swo[1] = sw_b; swo[2] = sw_c;
    er[0] = er_a;  er[1] = er_b;  er[2] = er_c;
  end

  stream_mux_sel #(.WIDTH(16), .NCH(4), .BLANK(2)) u_dut (
    .clk(clk), .rst(rst), .sel_req(sel_req[0]), .sel_load(sel_load[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(ir_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready[0]),
    .sel_cur(sc_a), .switching(sw_a), .sel_err(er_a));

  stream_mux_sel #(.WIDTH(16), .NCH(3), .BLANK(2)) u_dut_n3 (
    .clk(clk), .rst(rst), .sel_req(sel_req[1]), .sel_load(sel_load[1]),
    .in_data(in_data[1][47:0]), .in_valid(in_valid[1][2:0]), .in_ready(ir_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready[1]),
    .sel_cur(sc_b), .switching(sw_b), .sel_err(er_b));

  stream_mux_sel #(.WIDTH(16), .NCH(4), .BLANK(0)) u_dut_b0 (
    .clk(clk), .rst(rst), .sel_req(sel_req[2]), .sel_load(sel_load[2]),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(ir_c),
    .out_data(od_c), .out_valid(ov_c), .out_ready(out_ready[2]),
    .sel_cur(sc_c), .switching(sw_c), .sel_err(er_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: routed channel, optional held beat, and a switch in progress
  // described as "waiting for empty output" then "blank cycles left".
  int          nch_of[3] = '{4, 3, 4};
  int          blk_of[3] = '{2, 2, 0};
  int          m_cur[3], m_pend[3], m_blank_left[3];
  bit          m_sw[3], m_drain[3], m_hv[3], m_err[3];
  logic [15:0] m_hd[3];

  task automatic m_reset(input int i);
    m_cur[i] = 0; m_pend[i] = 0; m_blank_left[i] = 0;
    m_sw[i] = 0; m_drain[i] = 0; m_hv[i] = 0; m_err[i] = 0; m_hd[i] = '0;
  endtask

  task automatic m_check(input int i);
    logic [3:0] exp_ir;
    exp_ir = (!rst && !m_sw[i] && (!m_hv[i] || out_ready[i])) ? 4'(1 << m_cur[i]) : 4'b0;
    chk($sformatf("u%0d.in_ready", i), ir[i], exp_ir);
    chk($sformatf("u%0d.out_valid", i), ov[i], m_hv[i]);
    if (m_hv[i]) chk($sformatf("u%0d.out_data", i), od[i], m_hd[i]);
    chk($sformatf("u%0d.sel_cur", i), sc[i], m_cur[i]);
    chk($sformatf("u%0d.switching", i), swo[i], m_sw[i]);
    chk($sformatf("u%0d.sel_err", i), er[i], m_err[i]);
  endtask

  task automatic m_step(input int i);
    bit          ld, acc;
    logic [15:0] d;
    ld  = !m_hv[i] || out_ready[i];
    acc = !m_sw[i] && in_valid[i][m_cur[i]] && ld;
    d   = in_data[i][m_cur[i]*16 +: 16];
    m_err[i] = 0;
    if (!m_sw[i]) begin
      if (sel_load[i]) begin
        if (int'(sel_req[i]) >= nch_of[i]) m_err[i] = 1;
        else if (int'(sel_req[i]) != m_cur[i]) begin
          m_sw[i] = 1; m_drain[i] = 1; m_pend[i] = int'(sel_req[i]);
        end
      end
    end else begin
      if (sel_load[i]) m_err[i] = 1;
      if (m_drain[i]) begin
        if (ld) begin
          m_drain[i] = 0;
          m_blank_left[i] = blk_of[i];
          if (m_blank_left[i] == 0) begin m_sw[i] = 0; m_cur[i] = m_pend[i]; end
        end
      end else begin
        m_blank_left[i]--;
        if (m_blank_left[i] == 0) begin m_sw[i] = 0; m_cur[i] = m_pend[i]; end
      end
    end
    if (ld) begin
      m_hv[i] = acc;
      if (acc) m_hd[i] = d;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) m_reset(i);
      m_check(i);
      if (!rst) m_step(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      sel_req[i] = '0; sel_load[i] = 1'b0; in_data[i] = '0;
      in_valid[i] = '0; out_ready[i] = 1'b1;
      m_reset(i);
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_hold_in_ready", ir_a, 4'b0000);
    rst = 1'b0;
    #1;
    chk("idle_out_valid", ov_a, 1'b0);
    chk("idle_out_data", od_a, 16'h0000);
    chk("idle_sel_cur", sc_a, 2'd0);
    chk("idle_in_ready", ir_a, 4'b0001);
    chk("idle_switching", sw_a, 1'b0);

    // passthrough with one stall
    in_valid[0] = 4'b0001; in_data[0][15:0] = 16'h1111; tick();
    chk("pt_first", od_a, 16'h1111);
    chk("pt_first_valid", ov_a, 1'b1);
    in_data[0][15:0] = 16'h2222; tick();
    chk("pt_second", od_a, 16'h2222);
    out_ready[0] = 1'b0; in_data[0][15:0] = 16'h3333; #1;
    chk("pt_stall_ready", ir_a, 4'b0000);
    tick();
    chk("pt_hold", od_a, 16'h2222);
    out_ready[0] = 1'b1; #1;
    chk("pt_unstall_ready", ir_a, 4'b0001);
    tick();
    chk("pt_third", od_a, 16'h3333);
    in_valid[0] = 4'b0000; tick();
    chk("pt_drained", ov_a, 1'b0);

    // switch 0 -> 2 with a held, stalled beat
    out_ready[0] = 1'b0; in_valid[0] = 4'b0001; in_data[0][15:0] = 16'h2222; tick();
    in_valid[0] = 4'b0000; sel_load[0] = 1'b1; sel_req[0] = 2'd2; tick();
    sel_load[0] = 1'b0; in_valid[0] = 4'b0100; in_data[0][47:32] = 16'hAAAA; #1;
    chk("sw_switching", sw_a, 1'b1);
    chk("sw_in_ready", ir_a, 4'b0000);
    tick(); tick();
    chk("sw_hold", od_a, 16'h2222);
    chk("sw_hold_valid", ov_a, 1'b1);
    out_ready[0] = 1'b1; tick();
    chk("sw_fired", ov_a, 1'b0);
    chk("sw_blank_switching", sw_a, 1'b1);
    sel_load[0] = 1'b1; sel_req[0] = 2'd1; tick();
    chk("blank_err", er_a, 1'b1);
    chk("blank_sel_cur", sc_a, 2'd0);
    chk("blank_in_ready", ir_a, 4'b0000);
    sel_load[0] = 1'b0; tick();
    chk("sw_sel_cur", sc_a, 2'd2);
    chk("sw_done", sw_a, 1'b0);
    chk("sw_new_ready", ir_a, 4'b0100);
    chk("sw_err_clear", er_a, 1'b0);
    tick();
    chk("sw_first_beat", od_a, 16'hAAAA);
    chk("sw_first_valid", ov_a, 1'b1);

    // same-channel request
    sel_load[0] = 1'b1; sel_req[0] = 2'd2; tick();
    sel_load[0] = 1'b0;
    chk("same_err", er_a, 1'b0);
    chk("same_switching", sw_a, 1'b0);
    chk("same_ready", ir_a, 4'b0100);

    // NCH=3 illegal request
    sel_load[1] = 1'b1; sel_req[1] = 2'd3; tick();
    sel_load[1] = 1'b0;
    chk("ill_err", er_b, 1'b1);
    chk("ill_sel_cur", sc_b, 2'd0);
    tick();
    chk("ill_err_pulse", er_b, 1'b0);

    // BLANK=0: 0 -> 1, then 1 -> 3 with one idle cycle
    sel_load[2] = 1'b1; sel_req[2] = 2'd1; tick();
    sel_load[2] = 1'b0; tick();
    chk("b0_sel1", sc_c, 2'd1);
    chk("b0_ready1", ir_c, 4'b0010);
    sel_load[2] = 1'b1; sel_req[2] = 2'd3; tick();
    sel_load[2] = 1'b0;
    chk("b0_gap_ready", ir_c, 4'b0000);
    chk("b0_gap_switching", sw_c, 1'b1);
    tick();
    chk("b0_ready3", ir_c, 4'b1000);
    chk("b0_sel3", sc_c, 2'd3);
    chk("b0_done", sw_c, 1'b0);

    // async reset in the middle of BLANK
    in_valid[0] = 4'b0000; tick();
    sel_load[0] = 1'b1; sel_req[0] = 2'd1; tick();
    sel_load[0] = 1'b0; tick();
    chk("arst_pre_switching", sw_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel_cur", sc_a, 2'd0);
    chk("arst_switching", sw_a, 1'b0);
    chk("arst_in_ready", ir_a, 4'b0000);
    chk("arst_out_valid", ov_a, 1'b0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("arst_rel_sel_cur", sc_a, 2'd0);
    chk("arst_rel_in_ready", ir_a, 4'b0001);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        sel_load[i]  = ($urandom_range(0, 15) == 0);
        sel_req[i]   = 2'($urandom_range(0, 3));
        in_valid[i]  = 4'($urandom);
        in_data[i]   = {$urandom, $urandom};
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      if (n == 1500) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      sel_load[i] = 1'b0; in_valid[i] = '0; out_ready[i] = 1'b1;
    end
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
